// File: rtl/fp32_accumulator.sv
// Streaming IEEE-754 single-precision accumulator with one-step fpadder.
// Optional sticky overflow flag: define ACC_OVF_DETECT_EN.
module fpadder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] s
);
    logic        sbe, swap, sl, ss, stk, rnd;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [9:0]  el, es, diff, ex, sh;
    logic [23:0] ml, ms;
    logic [26:0] mfull, mse, nm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [24:0] rm;

    always_comb begin
        sbe   = b[31] ^ sub;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        swap  = b[30:0] > a[30:0];
        sl    = swap ? sbe : a[31];
        ss    = swap ? a[31] : sbe;
        el    = swap ? {2'b00, b[30:23]} : {2'b00, a[30:23]};
        es    = swap ? {2'b00, a[30:23]} : {2'b00, b[30:23]};
        ml    = swap ? {|b[30:23], b[22:0]} : {|a[30:23], a[22:0]};
        ms    = swap ? {|a[30:23], a[22:0]} : {|b[30:23], b[22:0]};
        // Denormals share the minimum normal exponent.
        if (el == 10'd0) el = 10'd1;
        if (es == 10'd0) es = 10'd1;
        diff  = el - es;
        mfull = {ms, 3'b000};
        mse   = 27'd0;
        stk   = 1'b0;
        if (diff >= 10'd27) begin
            stk = |ms;
        end else begin
            mse = mfull >> diff;
            stk = |(mfull & ((27'd1 << diff[4:0]) - 27'd1));
        end
        mse[0] = mse[0] | stk;
        if (sl == ss) sum = {1'b0, ml, 3'b000} + {1'b0, mse};
        else          sum = {1'b0, ml, 3'b000} - {1'b0, mse};
        lz = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
        ex = el;
        sh = 10'd0;
        nm = sum[26:0];
        if (sum[27]) begin
            nm = sum[27:1] | {26'd0, sum[0]};
            ex = el + 10'd1;
        end else begin
            sh = ({5'd0, lz} < (el - 10'd1)) ? {5'd0, lz} : (el - 10'd1);
            nm = sum[26:0] << sh;
            ex = el - sh;
        end
        rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
        rm  = {1'b0, nm[26:3]} + {24'd0, rnd};
        if (rm[24]) begin
            rm = rm >> 1;
            ex = ex + 10'd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sbe)))
            s = 32'h7FC00000;
        else if (a_inf)
            s = a;
        else if (b_inf)
            s = {sbe, b[30:0]};
        else if (sum == 28'd0)
            s = {sl & ss, 31'd0};
        else if (ex >= 10'd255)
            s = {sl, 8'hFF, 23'd0};
        else
            s = {sl, (rm[23] ? ex[7:0] : 8'h00), rm[22:0]};
    end
endmodule

module fp32_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy
`ifdef ACC_OVF_DETECT_EN
    ,
    output logic             ovf
`endif
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             xfer;

    fpadder u_add (
        .a   (acc_q),
        .b   (in_data),
        .sub (mode_q),
        .s   (sum)
    );

    assign xfer = (state_q == ACC) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 32'd0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 32'd0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = 32'd0;
                    cnt_d   = len;
                    mode_d  = mode;
                    state_d = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (xfer) begin
                    acc_d = sum;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1) state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ACC_OVF_DETECT_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && start) ovf_d = 1'b0;
        else if (xfer && sum[30:23] == 8'hFF) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif
endmodule
